// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: status codes, icodes, register ids and
// the decode-to-execute record with its bubble (NOP) constant.
package y86_pkg;

  localparam int Y86_WORD_W = 64;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  // Narrow control part of the record; width-independent so any WORD_W reuses it.
  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] rA;
    logic [3:0] rB;
  } exe_hdr_t;

  localparam exe_hdr_t EXE_HDR_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    ifun:  4'h0,
    rA:    RNONE,
    rB:    RNONE
  };

  typedef struct packed {
    exe_hdr_t                hdr;
    logic [Y86_WORD_W-1:0]   valA;
    logic [Y86_WORD_W-1:0]   valB;
    logic [Y86_WORD_W-1:0]   valC;
    logic [Y86_WORD_W-1:0]   valP;
  } exe_rec_t;

  localparam exe_rec_t EXE_BUBBLE = '{
    hdr:  EXE_HDR_BUBBLE,
    valA: '0,
    valB: '0,
    valC: '0,
    valP: '0
  };

endpackage

// File: rtl/pipe_event_cnt.sv
// Event counter with synchronous reset, clear and enable; either saturates at
// all-ones (SATURATE=1) or wraps modulo 2^W (SATURATE=0).
module pipe_event_cnt #(
  parameter int W        = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_q
);

  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (SATURATE && (&cnt_q)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/execute_stage_reg.sv
// Decode-to-execute pipeline register with reset/bubble/stall control, stall
// watchdog and sticky conflict flag. EXECUTE_STAGE_REG_PERF_EN adds perf counters.
module execute_stage_reg
  import y86_pkg::*;
#(
  parameter int WORD_W      = 64,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              bubble_e,
  input  logic [2:0]        stat_d,
  input  logic [3:0]        icode_d,
  input  logic [3:0]        ifun_d,
  input  logic [3:0]        rA_d,
  input  logic [3:0]        rB_d,
  input  logic [WORD_W-1:0] valA_d,
  input  logic [WORD_W-1:0] valB_d,
  input  logic [WORD_W-1:0] valC_d,
  input  logic [WORD_W-1:0] valP_d,
  output logic [2:0]        stat_e,
  output logic [3:0]        icode_e,
  output logic [3:0]        ifun_e,
  output logic [3:0]        rA_e,
  output logic [3:0]        rB_e,
  output logic [WORD_W-1:0] valA_e,
  output logic [WORD_W-1:0] valB_e,
  output logic [WORD_W-1:0] valC_e,
  output logic [WORD_W-1:0] valP_e,
  output logic              valid_e,
  output logic              stall_timeout,
  output logic              ctrl_conflict
`ifdef EXECUTE_STAGE_REG_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stalls,
  output logic [CNT_W-1:0]  perf_bubbles
`endif
);

  typedef struct packed {
    exe_hdr_t          hdr;
    logic [WORD_W-1:0] valA;
    logic [WORD_W-1:0] valB;
    logic [WORD_W-1:0] valC;
    logic [WORD_W-1:0] valP;
  } rec_t;

  localparam rec_t REC_BUBBLE = '{
    hdr:  EXE_HDR_BUBBLE,
    valA: '0,
    valB: '0,
    valC: '0,
    valP: '0
  };

  // Control priority per edge: rst > bubble_e > stall_e > load.
  // A stall is only "taken" when no bubble and no reset share the edge.
  logic stall_take;
  logic bubble_take;

  assign stall_take  = stall_e && !bubble_e && !rst;
  assign bubble_take = bubble_e && !rst;

  rec_t rec_d, rec_q;
  logic valid_d, valid_q;
  logic conflict_d, conflict_q;
  logic timeout_d, timeout_q;
  logic [CNT_W-1:0] run_q;

  always_comb begin
    rec_d      = rec_q;
    valid_d    = valid_q;
    conflict_d = conflict_q;
    if (rst) begin
      rec_d      = REC_BUBBLE;
      valid_d    = 1'b0;
      conflict_d = 1'b0;
    end else if (bubble_e) begin
      rec_d   = REC_BUBBLE;
      valid_d = 1'b0;
      if (stall_e) begin
        conflict_d = 1'b1;
      end
    end else if (!stall_e) begin
      rec_d.hdr.stat  = stat_d;
      rec_d.hdr.icode = icode_d;
      rec_d.hdr.ifun  = ifun_d;
      rec_d.hdr.rA    = rA_d;
      rec_d.hdr.rB    = rB_d;
      rec_d.valA      = valA_d;
      rec_d.valB      = valB_d;
      rec_d.valC      = valC_d;
      rec_d.valP      = valP_d;
      valid_d         = 1'b1;
    end
  end

  // Stall-run length; cleared by any edge that does not take a stall.
  pipe_event_cnt #(
    .W        (CNT_W),
    .SATURATE (1'b1)
  ) u_stall_run (
    .clk   (clk),
    .rst   (rst),
    .clr   (!stall_take),
    .en    (stall_take),
    .cnt_q (run_q)
  );

  // The counter after this edge is sat(run_q+1) when stalling, so it reaches
  // STALL_LIMIT exactly when run_q is already at STALL_LIMIT-1 or beyond.
  always_comb begin
    timeout_d = 1'b0;
    if (stall_take) begin
      timeout_d = (64'(run_q) >= 64'(STALL_LIMIT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q      <= REC_BUBBLE;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      rec_q      <= rec_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
    end
  end

  assign stat_e        = rec_q.hdr.stat;
  assign icode_e       = rec_q.hdr.icode;
  assign ifun_e        = rec_q.hdr.ifun;
  assign rA_e          = rec_q.hdr.rA;
  assign rB_e          = rec_q.hdr.rB;
  assign valA_e        = rec_q.valA;
  assign valB_e        = rec_q.valB;
  assign valC_e        = rec_q.valC;
  assign valP_e        = rec_q.valP;
  assign valid_e       = valid_q;
  assign stall_timeout = timeout_q;
  assign ctrl_conflict = conflict_q;

`ifdef EXECUTE_STAGE_REG_PERF_EN
  pipe_event_cnt #(
    .W        (CNT_W),
    .SATURATE (1'b0)
  ) u_perf_stalls (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (stall_take),
    .cnt_q (perf_stalls)
  );

  pipe_event_cnt #(
    .W        (CNT_W),
    .SATURATE (1'b0)
  ) u_perf_bubbles (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (bubble_take),
    .cnt_q (perf_bubbles)
  );
`else
  logic unused_bubble_take;
  assign unused_bubble_take = bubble_take;
`endif

endmodule
